oam_dma_ctrl: RTL and testbench
===============================

OAM_DMA_CTRL -- requirements
Module: oam_dma_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default `REG_WIDTH (8), meaning data bus width.
REQ-002 SHALL have parameter ADDR_WIDTH, default `ADDR_WIDTH (16), meaning address bus width.
REQ-003 SHALL have parameter TRIG_ADDR, default 16'h4014, meaning the CPU write address that starts a DMA.
REQ-004 SHALL have parameter DEST_ADDR, default 16'h2004, meaning the fixed DMA destination address.
REQ-005 SHALL have port clk, input, 1, meaning the single system clock; all state changes on its rising edge.
REQ-006 SHALL have port reset_n, input, 1, meaning synchronous, active-low reset.
REQ-007 SHALL have ports cpu_addr (input, ADDR_WIDTH), cpu_din (input, WIDTH, CPU write data) and cpu_we (input, 1, CPU write enable).
REQ-008 SHALL have port cpu_dout, output, WIDTH, meaning read data returned to the CPU.
REQ-009 SHALL have port cpu_rdy, output, 1, meaning 1 = CPU may run, 0 = CPU stalled.
REQ-010 SHALL have ports mem_addr (output, ADDR_WIDTH), mem_din (output, WIDTH) and mem_we (output, 1), which drive the shared mem block.
REQ-011 SHALL have port mem_dout, input, WIDTH, meaning combinational read data from mem; valid only while mem_we=0.
REQ-012 SHALL have port dma_busy, output, 1, meaning high in every state except IDLE.

Function
REQ-013 SHALL implement states IDLE, HALT, ALIGN, READ and WRITE.
REQ-014 In IDLE, the block SHALL pass through combinationally: mem_addr=cpu_addr, mem_din=cpu_din, mem_we=cpu_we, cpu_dout=mem_dout, cpu_rdy=1.
REQ-015 In IDLE, cpu_we=1 with cpu_addr==TRIG_ADDR SHALL latch page=cpu_din, clear byte_cnt to 0, force mem_we=0 for that cycle (trigger write is not forwarded) and go to HALT next cycle.
REQ-016 A free-running 1-bit parity register SHALL toggle every clock.
REQ-017 HALT SHALL last one cycle, then go to ALIGN if parity==1 during HALT, otherwise to READ.
REQ-018 ALIGN SHALL last one cycle and then go to READ.
REQ-019 In READ, the block SHALL drive mem_addr={page, byte_cnt} and mem_we=0, and capture mem_dout into data_reg at the clock edge; next state is WRITE.
REQ-020 In WRITE, the block SHALL drive mem_addr=DEST_ADDR, mem_din=data_reg and mem_we=1; byte_cnt SHALL increment by 1 (8-bit, wraps).
REQ-021 From WRITE, the next state SHALL be IDLE if byte_cnt was 8'hFF before the increment, otherwise READ; exactly 256 bytes are copied.
REQ-022 The cpu_rdy=0 window SHALL last exactly 513 cycles (HALT+512) or 514 cycles (with ALIGN).
REQ-023 In all non-IDLE states, cpu_rdy SHALL be 0 and cpu_addr, cpu_din and cpu_we SHALL be ignored, including a new trigger; cpu_dout SHALL be driven with mem_dout.
REQ-024 In HALT and ALIGN, mem_we SHALL be 0 and mem_addr SHALL be {page, 8'h00}.
REQ-025 Page 8'hFF SHALL be handled with no special case (source range FF00–FFFF).

Reset
REQ-026 reset_n=0 at a clock edge SHALL force state=IDLE, page=0, byte_cnt=0, data_reg=0 and parity=0, from any state including mid-DMA.
REQ-027 During and after reset, the outputs SHALL be cpu_rdy=1 and dma_busy=0, with the IDLE passthrough active.
REQ-028 An aborted DMA SHALL not resume after reset.

Structure
REQ-029 A shared package SHALL hold the state enum typedef and the constants TRIG_ADDR, DEST_ADDR and DMA_LEN (256).
REQ-030 The block SHALL be a single module with no sub-module; the passthrough mux is inline.
REQ-031 The bench SHALL instance the existing mem block (TEST_RUN override and monitor) behind oam_dma_ctrl.

Verification
REQ-032 Passthrough: in IDLE, CPU write 8'h3C to 16'h0010, then read 16'h0010 -> cpu_dout=8'h3C, cpu_rdy=1, dma_busy=0.
REQ-033 Even-parity DMA: preload page 2 with byte[i]=i^8'hA5, write 8'h02 to 16'h4014 with parity=0 at HALT -> 256 writes to 16'h2004 with data A5,A4,…,5A in order; cpu_rdy low for exactly 513 cycles.
REQ-034 Odd-parity DMA: same stimulus with parity=1 at HALT -> one ALIGN cycle observed, cpu_rdy low for exactly 514 cycles, same data sequence.
REQ-035 Trigger suppression: write to 16'h4014 -> mem_we=0 on the trigger cycle; re-trigger attempts during DMA cause no restart and the total byte count stays 256.
REQ-036 Reset mid-DMA: assert reset_n=0 after 100 bytes -> next cycle state=IDLE, cpu_rdy=1 and no further writes to 16'h2004.
REQ-037 Page wrap: trigger with page 8'hFF -> reads span FF00–FFFF and the last read address is 16'hFFFF.

Source files
------------

// File: rtl/oam_dma_ctrl_pkg.sv
// Shared types and constants for the OAM DMA controller: state encoding,
// default bus widths and the fixed trigger/destination addresses.
package oam_dma_ctrl_pkg;

    localparam int unsigned REG_WIDTH      = 8;
    localparam int unsigned DEF_ADDR_WIDTH = 16;
    localparam int unsigned CNT_WIDTH      = 8;
    localparam int unsigned DMA_LEN        = 256;

    localparam logic [15:0] TRIG_ADDR = 16'h4014;
    localparam logic [15:0] DEST_ADDR = 16'h2004;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HALT  = 3'd1,
        ST_ALIGN = 3'd2,
        ST_READ  = 3'd3,
        ST_WRITE = 3'd4
    } dma_state_e;

endpackage

// File: rtl/oam_dma_ctrl.sv
// OAM DMA controller: a CPU write to the trigger address stalls the CPU and
// copies one 256-byte page to a fixed destination, one read/write pair per byte.
module oam_dma_ctrl #(
    parameter int unsigned WIDTH      = oam_dma_ctrl_pkg::REG_WIDTH,
    parameter int unsigned ADDR_WIDTH = oam_dma_ctrl_pkg::DEF_ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] TRIG_ADDR = ADDR_WIDTH'(oam_dma_ctrl_pkg::TRIG_ADDR),
    parameter logic [ADDR_WIDTH-1:0] DEST_ADDR = ADDR_WIDTH'(oam_dma_ctrl_pkg::DEST_ADDR)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [WIDTH-1:0]      cpu_din,
    input  logic                  cpu_we,
    output logic [WIDTH-1:0]      cpu_dout,
    output logic                  cpu_rdy,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0]      mem_din,
    output logic                  mem_we,
    input  logic [WIDTH-1:0]      mem_dout,
    output logic                  dma_busy
);

    import oam_dma_ctrl_pkg::*;

    dma_state_e           state;
    dma_state_e           state_nxt;
    dma_state_e           out_state;
    logic [WIDTH-1:0]     page;
    logic [CNT_WIDTH-1:0] byte_cnt;
    logic [WIDTH-1:0]     data_reg;
    logic                 parity;
    logic                 trig_c;
    logic                 last_byte_c;

    assign trig_c      = cpu_we && (cpu_addr == TRIG_ADDR);
    assign last_byte_c = (byte_cnt == CNT_WIDTH'(DMA_LEN - 1));

    // Outputs fall back to the idle passthrough while reset is held
    assign out_state = reset_n ? state : ST_IDLE;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            page     <= '0;
            byte_cnt <= '0;
            data_reg <= '0;
            parity   <= 1'b0;
        end else begin
            parity <= ~parity;
            case (state)
                ST_IDLE: begin
                    if (trig_c) begin
                        page     <= cpu_din;
                        byte_cnt <= '0;
                    end
                end
                ST_READ:  data_reg <= mem_dout;
                ST_WRITE: byte_cnt <= CNT_WIDTH'(byte_cnt + 1'b1);
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (trig_c) state_nxt = ST_HALT;
            ST_HALT:  state_nxt = parity ? ST_ALIGN : ST_READ;
            ST_ALIGN: state_nxt = ST_READ;
            ST_READ:  state_nxt = ST_WRITE;
            ST_WRITE: state_nxt = last_byte_c ? ST_IDLE : ST_READ;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // CPU bus is ignored in every busy state; only IDLE forwards it to memory
    always_comb begin
        cpu_dout = mem_dout;
        cpu_rdy  = 1'b0;
        dma_busy = 1'b1;
        mem_addr = ADDR_WIDTH'({page, CNT_WIDTH'(0)});
        mem_din  = data_reg;
        mem_we   = 1'b0;
        case (out_state)
            ST_IDLE: begin
                cpu_rdy  = 1'b1;
                dma_busy = 1'b0;
                mem_addr = cpu_addr;
                mem_din  = cpu_din;
                mem_we   = cpu_we && !trig_c;
            end
            ST_READ: begin
                mem_addr = ADDR_WIDTH'({page, byte_cnt});
            end
            ST_WRITE: begin
                mem_addr = DEST_ADDR;
                mem_we   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Bench for oam_dma_ctrl: a flat memory array behind the controller, a
// cycle-offset reference model of the DMA timeline and directed/random traffic.
module tb_oam_dma_ctrl;

    import oam_dma_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_din;
    logic        cpu_we;
    logic [7:0]  cpu_dout;
    logic        cpu_rdy;
    logic [15:0] mem_addr;
    logic [7:0]  mem_din;
    logic        mem_we;
    logic [7:0]  mem_dout;
    logic        dma_busy;

    always #5 clk = ~clk;

    oam_dma_ctrl dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .cpu_addr (cpu_addr),
        .cpu_din  (cpu_din),
        .cpu_we   (cpu_we),
        .cpu_dout (cpu_dout),
        .cpu_rdy  (cpu_rdy),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_we   (mem_we),
        .mem_dout (mem_dout),
        .dma_busy (dma_busy)
    );

    // Shared memory: combinational read, synchronous write, one-shot fill
    logic [7:0] mem [0:65535];
    logic       fill_req;
    assign mem_dout = mem[mem_addr];

    always @(posedge clk) begin
        if (fill_req) begin
            for (int i = 0; i < 65536; i++) mem[i] <= 8'($urandom);
            for (int i = 0; i < 256; i++) begin
                mem[{8'h02, 8'(i)}] <= 8'(i) ^ 8'hA5;
                mem[{8'hFF, 8'(i)}] <= 8'(i) ^ 8'hA5;
            end
        end else if (mem_we) begin
            mem[mem_addr] <= mem_din;
        end
    end

    // Log of every byte landing on the destination address
    int         wr_cnt = 0;
    logic [7:0] wr_log [0:4095];
    always @(posedge clk) begin
        if (mem_we && mem_addr == DEST_ADDR) begin
            wr_log[wr_cnt[11:0]] <= mem_din;
            wr_cnt <= wr_cnt + 1;
        end
    end

    // Reference model: cycle offset k since the trigger (k=1 is the halt cycle)
    int         m_r = 0;
    logic       m_active = 1'b0;
    int         m_k = 0;
    logic [7:0] m_page = 8'h00;
    logic       m_align = 1'b0;
    always @(posedge clk) begin
        if (!reset_n) begin
            m_r      <= 0;
            m_active <= 1'b0;
            m_k      <= 0;
        end else begin
            m_r <= m_r + 1;
            if (m_active) begin
                if (m_k == 1 + int'(m_align) + 2 * int'(DMA_LEN)) m_active <= 1'b0;
                else m_k <= m_k + 1;
            end else if (cpu_we && cpu_addr == TRIG_ADDR) begin
                m_active <= 1'b1;
                m_k      <= 1;
                m_page   <= cpu_din;
                m_align  <= ~m_r[0];
            end
        end
    end

    int          vectors = 0;
    int          miscompares = 0;
    logic [15:0] last_rd = 16'h0000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cycle_compare();
        logic [15:0] ea;
        logic [7:0]  ed;
        logic        ew, er, eb, dv;
        int          pre, j;
        ea = cpu_addr; ed = cpu_din; ew = 1'b0; er = 1'b1; eb = 1'b0; dv = 1'b1;
        if (!reset_n || !m_active) begin
            ew = cpu_we && (cpu_addr != TRIG_ADDR);
        end else begin
            er  = 1'b0;
            eb  = 1'b1;
            dv  = 1'b0;
            pre = 1 + int'(m_align);
            if (m_k <= pre) begin
                ea = {m_page, 8'h00};
            end else begin
                j = m_k - pre - 1;
                if (j % 2 == 0) begin
                    ea = {m_page, 8'(j / 2)};
                end else begin
                    ea = DEST_ADDR;
                    ew = 1'b1;
                    dv = 1'b1;
                    ed = mem[{m_page, 8'(j / 2)}];
                end
            end
        end
        check("cpu_rdy", 32'(cpu_rdy), 32'(er));
        check("dma_busy", 32'(dma_busy), 32'(eb));
        check("mem_we", 32'(mem_we), 32'(ew));
        check("mem_addr", 32'(mem_addr), 32'(ea));
        if (dv) check("mem_din", 32'(mem_din), 32'(ed));
        check("cpu_dout", 32'(cpu_dout), 32'(mem[ea]));
        if (dma_busy && !mem_we) last_rd = mem_addr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Fire the trigger in a cycle chosen so parity during HALT equals halt_par
    task automatic do_trigger(input logic [7:0] pg, input logic halt_par, output int base);
        for (int i = 0; i < 4 && m_r[0] == halt_par; i++) tick();
        base     = wr_cnt;
        cpu_we   = 1'b1;
        cpu_addr = TRIG_ADDR;
        cpu_din  = pg;
        @(negedge clk);
        check("trig_mem_we", 32'(mem_we), 32'd0);
    endtask

    // Run until cpu_rdy returns, applying junk (or re-trigger) CPU traffic
    task automatic wait_done(input logic retrig, output int low);
        logic done;
        done = 1'b0;
        low  = 0;
        for (int c = 0; c < 700 && !done; c++) begin
            tick();
            if (retrig && c >= 5 && c < 12) begin
                cpu_we = 1'b1; cpu_addr = TRIG_ADDR; cpu_din = 8'($urandom);
            end else begin
                cpu_we = 1'($urandom); cpu_addr = {8'h01, 8'($urandom)}; cpu_din = 8'($urandom);
            end
            @(negedge clk);
            if (cpu_rdy) done = 1'b1;
            else low++;
        end
        check("dma_done", 32'(done), 32'd1);
        tick();
        cpu_we = 1'b0;
    endtask

    initial begin
        int  base, low;
        logic par;
        logic [7:0] pg;
        reset_n  = 1'b0;
        cpu_we   = 1'b0;
        cpu_addr = 16'h0000;
        cpu_din  = 8'h00;
        fill_req = 1'b1;
        fork
            forever begin
                @(negedge clk);
                cycle_compare();
            end
        join_none
        tick();
        fill_req = 1'b0;
        tick();
        @(negedge clk);
        check("rst_cpu_rdy", 32'(cpu_rdy), 32'd1);
        check("rst_dma_busy", 32'(dma_busy), 32'd0);
        tick();
        reset_n = 1'b1;

        // Passthrough write then read back
        cpu_we = 1'b1; cpu_addr = 16'h0010; cpu_din = 8'h3C;
        tick();
        cpu_we = 1'b0;
        @(negedge clk);
        check("pt_dout", 32'(cpu_dout), 32'h3C);
        check("pt_rdy", 32'(cpu_rdy), 32'd1);
        check("pt_busy", 32'(dma_busy), 32'd0);
        tick();

        // Even and odd parity copies of page 2
        for (int p = 0; p < 2; p++) begin
            do_trigger(8'h02, 1'(p), base);
            wait_done(1'b0, low);
            check("low_cycles", 32'(low), (p == 0) ? 32'd513 : 32'd514);
            check("byte_count", 32'(wr_cnt - base), 32'd256);
            check("first_byte", 32'(wr_log[12'(base)]), 32'hA5);
            check("byte_16", 32'(wr_log[12'(base + 16)]), 32'hB5);
            check("last_byte", 32'(wr_log[12'(base + 255)]), 32'h5A);
        end

        // Re-trigger attempts while busy
        par = 1'($urandom);
        do_trigger(8'h02, par, base);
        wait_done(1'b1, low);
        check("retrig_low", 32'(low), par ? 32'd514 : 32'd513);
        check("retrig_count", 32'(wr_cnt - base), 32'd256);

        // Reset after 100 bytes; DMA must not resume
        do_trigger(8'h03, 1'b0, base);
        for (int c = 0; c < 400 && (wr_cnt - base) < 100; c++) begin
            tick();
            cpu_we = 1'b0;
        end
        check("abort_at", 32'(wr_cnt - base), 32'd100);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        @(negedge clk);
        check("abort_rdy", 32'(cpu_rdy), 32'd1);
        check("abort_busy", 32'(dma_busy), 32'd0);
        repeat (600) tick();
        check("abort_count", 32'(wr_cnt - base), 32'd100);

        // Page FF wraps to the top of the address space
        do_trigger(8'hFF, 1'($urandom), base);
        wait_done(1'b0, low);
        check("ff_last_rd", 32'(last_rd), 32'hFFFF);
        check("ff_count", 32'(wr_cnt - base), 32'd256);
        check("ff_first", 32'(wr_log[12'(base)]), 32'hA5);

        // Random idle traffic mixed with random-page copies
        for (int n = 0; n < 3; n++) begin
            for (int c = 0; c < 60; c++) begin
                tick();
                cpu_we   = 1'($urandom);
                cpu_addr = cpu_we ? {8'h01, 8'($urandom)} : 16'($urandom);
                if (cpu_addr == TRIG_ADDR) cpu_addr = 16'h0000;
                cpu_din  = 8'($urandom);
            end
            pg = 8'($urandom);
            if (pg == 8'h20) pg = 8'h21;
            do_trigger(pg, 1'($urandom), base);
            wait_done(1'($urandom), low);
            check("rnd_count", 32'(wr_cnt - base), 32'd256);
        end
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
